// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU control path: opcodes, ALU control
// classes and the control FSM state type.
package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   localparam logic [2:0] ALU_RTYPE = 3'b000;
   localparam logic [2:0] ALU_ADD   = 3'b001;
   localparam logic [2:0] ALU_SUB   = 3'b010;

   // WB_I is the reg_dst=0 write-back used by addi.
   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WB,
      S_MEM_WR,
      S_WB_R,
      S_WB_I,
      S_BRANCH,
      S_ERR
   } state_e;

   function automatic state_e decode_target(input logic [5:0] op);
      state_e nxt;
      case (op)
         OP_RTYPE:      nxt = S_EXEC_R;
         OP_ADDI:       nxt = S_EXEC_I;
         OP_LW, OP_SW:  nxt = S_MEM_ADDR;
         OP_BEQ:        nxt = S_BRANCH;
         default:       nxt = S_ERR;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/control_decode.sv
// Output decode for the multicycle controller: datapath strobes and selects
// from the current state (plus the fetch handshake for IR/PC latching).
module control_decode
   import cpu_pkg::*;
(
   input  state_e     state,
   input  logic       mem_ready,
   output logic [2:0] ALUOp,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       alu_src,
   output logic       mem_to_reg,
   output logic       iord,
   output logic       busy,
   output logic       error
);

   always_comb begin
      ALUOp         = ALU_RTYPE;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      alu_src       = 1'b0;
      mem_to_reg    = 1'b0;
      iord          = 1'b0;
      busy          = (state != S_IDLE);
      error         = 1'b0;
      case (state)
         S_FETCH: begin
            mem_read = 1'b1;
            ALUOp    = ALU_ADD;
            ir_write = mem_ready;
            pc_write = mem_ready;
         end
         S_DECODE:   ALUOp = ALU_ADD;
         S_EXEC_R:   ALUOp = ALU_RTYPE;
         S_EXEC_I, S_MEM_ADDR: begin
            ALUOp   = ALU_ADD;
            alu_src = 1'b1;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         S_WB_R: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_WB_I:     reg_write = 1'b1;
         S_BRANCH: begin
            ALUOp         = ALU_SUB;
            pc_write_cond = 1'b1;
         end
         S_ERR:      error = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM with retired-instruction counter; output decoding
// lives in control_decode.
module multicycle_control
   import cpu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   input  logic             zero,
   output logic [2:0]       ALUOp,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             ir_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             alu_src,
   output logic             mem_to_reg,
   output logic             iord,
   output logic             busy,
   output logic             error,
   output logic [CNT_W-1:0] retired
);

   state_e           state_q, state_d;
   logic             is_store_q, is_store_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             complete;

   // The branch decision is taken in the datapath, so zero is not needed here.
   logic unused_zero;
   assign unused_zero = zero;

   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      retired_d  = retired_q;
      complete   = 1'b0;
      case (state_q)
         S_IDLE:     if (run) state_d = S_FETCH;
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            // opcode is only valid here, so remember load vs store for MEM_ADDR.
            state_d    = decode_target(opcode);
            is_store_d = (opcode == OP_SW);
         end
         S_EXEC_R:   state_d = S_WB_R;
         S_EXEC_I:   state_d = S_WB_I;
         S_MEM_ADDR: state_d = is_store_q ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WR:   complete = mem_ready;
         S_MEM_WB, S_WB_R, S_WB_I, S_BRANCH: complete = 1'b1;
         S_ERR:      if (!run) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
      if (complete) begin
         retired_d = retired_q + CNT_W'(1);
         state_d   = run ? S_FETCH : S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         is_store_q <= 1'b0;
         retired_q  <= '0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         retired_q  <= retired_d;
      end
   end

   assign retired = retired_q;

   control_decode u_decode (
      .state         (state_q),
      .mem_ready     (mem_ready),
      .ALUOp         (ALUOp),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .ir_write      (ir_write),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .reg_write     (reg_write),
      .reg_dst       (reg_dst),
      .alu_src       (alu_src),
      .mem_to_reg    (mem_to_reg),
      .iord          (iord),
      .busy          (busy),
      .error         (error)
   );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus random
// traffic, compared against an instruction-step reference model.
module tb_multicycle_control;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n, run, mem_ready, zero;
   logic [5:0]       opcode;
   logic [2:0]       alu_op;
   logic             pc_write, pc_write_cond, ir_write, mem_read, mem_write;
   logic             reg_write, reg_dst, alu_src, mem_to_reg, iord, busy, error;
   logic [CNT_W-1:0] retired;
   logic [14:0]      obs_vec;

   int total = 0;
   int bad   = 0;

   // Reference model: activity mode, instruction class and step within it.
   localparam int MD_IDLE = 0, MD_EXEC = 1, MD_ERR = 2;
   localparam int CL_R = 0, CL_I = 1, CL_LW = 2, CL_SW = 3, CL_BR = 4;
   int m_mode, m_cls, m_step, m_retired;

   multicycle_control #(.CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .run           (run),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .zero          (zero),
      .ALUOp         (alu_op),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .ir_write      (ir_write),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .reg_write     (reg_write),
      .reg_dst       (reg_dst),
      .alu_src       (alu_src),
      .mem_to_reg    (mem_to_reg),
      .iord          (iord),
      .busy          (busy),
      .error         (error),
      .retired       (retired)
   );

   always #5 clk = ~clk;

   assign obs_vec = {alu_op, pc_write, pc_write_cond, ir_write, mem_read, mem_write,
                     reg_write, reg_dst, alu_src, mem_to_reg, iord, busy, error};

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int last_step(input int cls);
      if (cls == CL_BR) return 2;
      if (cls == CL_LW) return 4;
      return 3;
   endfunction

   function automatic bit waits_for_mem();
      return (m_step == 0) || (m_step == 3 && (m_cls == CL_LW || m_cls == CL_SW));
   endfunction

   // Expected output vector, same field order as obs_vec.
   function automatic logic [14:0] model_outputs(input logic mr);
      logic [2:0] alu;
      logic pw, pwc, irw, mrd, mwr, rw, rd, as, mtr, io, bsy, er;
      alu = 3'd0; pw = 0; pwc = 0; irw = 0; mrd = 0; mwr = 0;
      rw = 0; rd = 0; as = 0; mtr = 0; io = 0; bsy = 0; er = 0;
      if (m_mode == MD_ERR) begin
         bsy = 1; er = 1;
      end else if (m_mode == MD_EXEC) begin
         bsy = 1;
         if (m_step == 0) begin
            mrd = 1; alu = 3'd1; irw = mr; pw = mr;
         end else if (m_step == 1) begin
            alu = 3'd1;
         end else if (m_cls == CL_BR) begin
            alu = 3'd2; pwc = 1;
         end else if (m_step == 2) begin
            if (m_cls == CL_R) alu = 3'd0;
            else begin alu = 3'd1; as = 1; end
         end else if (m_step == 3) begin
            case (m_cls)
               CL_R:    begin rw = 1; rd = 1; end
               CL_I:    rw = 1;
               CL_LW:   begin mrd = 1; io = 1; end
               default: begin mwr = 1; io = 1; end
            endcase
         end else begin
            rw = 1; mtr = 1;
         end
      end
      return {alu, pw, pwc, irw, mrd, mwr, rw, rd, as, mtr, io, bsy, er};
   endfunction

   task automatic model_step(input logic r_n, input logic rn, input logic [5:0] op, input logic mr);
      if (!r_n) begin
         m_mode = MD_IDLE; m_retired = 0; m_step = 0;
      end else if (m_mode == MD_IDLE) begin
         if (rn) begin m_mode = MD_EXEC; m_step = 0; end
      end else if (m_mode == MD_ERR) begin
         if (!rn) m_mode = MD_IDLE;
      end else if (waits_for_mem() && !mr) begin
         m_step = m_step;
      end else if (m_step == 1) begin
         m_step = 2;
         case (op)
            6'h00:   m_cls = CL_R;
            6'h08:   m_cls = CL_I;
            6'h23:   m_cls = CL_LW;
            6'h2B:   m_cls = CL_SW;
            6'h04:   m_cls = CL_BR;
            default: m_mode = MD_ERR;
         endcase
      end else if (m_step == last_step(m_cls)) begin
         m_retired = (m_retired + 1) % (1 << CNT_W);
         m_step = 0;
         if (!rn) m_mode = MD_IDLE;
      end else begin
         m_step++;
      end
   endtask

   // One clock: drive inputs, check at the falling edge, advance the model at the rising edge.
   task automatic applyStimulus(input string tag, input logic r_n, input logic rn,
                                input logic [5:0] op, input logic mr);
      rst_n = r_n; run = rn; opcode = op; mem_ready = mr;
      zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput({tag, ".outs"}, 32'(obs_vec), 32'(model_outputs(mr)));
      checkOutput({tag, ".retired"}, 32'(retired), 32'(m_retired));
      @(posedge clk);
      model_step(r_n, rn, op, mr);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 12 && m_mode != MD_IDLE; i++)
         applyStimulus("drain", 1, 0, 6'h00, 1);
      checkOutput("drain.idle", 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      applyStimulus("rst0", 0, 1, 6'h00, 1);
      applyStimulus("rst1", 0, 1, 6'h00, 1);
      checkOutput("reset.outs", 32'(obs_vec), 32'd0);
      checkOutput("reset.retired", 32'(retired), 32'd0);
   endtask

   initial begin
      int saved;
      logic [5:0] ops [6];
      ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h23;
      ops[3] = 6'h2B; ops[4] = 6'h04; ops[5] = 6'h3F;
      m_mode = MD_IDLE; m_cls = CL_R; m_step = 0; m_retired = 0;
      rst_n = 0; run = 0; opcode = 6'h00; mem_ready = 0; zero = 0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // R-type, four cycles to completion
      applyStimulus("r.idle",   1, 1, 6'h00, 1);
      applyStimulus("r.fetch",  1, 1, 6'h00, 1);
      applyStimulus("r.decode", 1, 1, 6'h00, 1);
      checkOutput("r.exec_aluop", 32'(alu_op), 32'd0);
      applyStimulus("r.exec",   1, 1, 6'h00, 1);
      checkOutput("r.wb_regdst", 32'({reg_write, reg_dst}), 32'h3);
      applyStimulus("r.wb",     1, 1, 6'h00, 1);
      checkOutput("r.retired1", 32'(retired), 32'd1);
      drain();

      // lw with three memory stall cycles in the read
      saved = m_retired;
      applyStimulus("lw.idle",   1, 1, 6'h23, 1);
      applyStimulus("lw.fetch",  1, 1, 6'h23, 1);
      applyStimulus("lw.decode", 1, 1, 6'h23, 1);
      applyStimulus("lw.addr",   1, 1, 6'h23, 1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus("lw.stall", 1, 1, 6'h23, 0);
         checkOutput("lw.still_rd", 32'({mem_read, iord}), 32'h3);
      end
      applyStimulus("lw.rd", 1, 1, 6'h23, 1);
      checkOutput("lw.mem_to_reg", 32'(mem_to_reg), 32'd1);
      applyStimulus("lw.wb", 1, 0, 6'h23, 1);
      checkOutput("lw.retired", 32'(retired), 32'((saved + 1) % 16));
      drain();

      // illegal opcode parks in ERR until run drops
      saved = m_retired;
      applyStimulus("err.idle",   1, 1, 6'h3F, 1);
      applyStimulus("err.fetch",  1, 1, 6'h3F, 1);
      applyStimulus("err.decode", 1, 1, 6'h3F, 1);
      checkOutput("err.flag", 32'({busy, error}), 32'h3);
      applyStimulus("err.hold", 1, 1, 6'h00, 1);
      applyStimulus("err.exit", 1, 0, 6'h00, 1);
      checkOutput("err.idle_outs", 32'(obs_vec), 32'd0);
      checkOutput("err.retired", 32'(retired), 32'(saved));

      // sixteen back-to-back beq wrap the 4-bit counter
      do_reset();
      applyStimulus("beq.idle", 1, 1, 6'h04, 1);
      for (int n = 1; n <= 16; n++) begin
         applyStimulus("beq.fetch",  1, 1, 6'h04, 1);
         applyStimulus("beq.decode", 1, 1, 6'h04, 1);
         checkOutput("beq.aluop_pwc", 32'({alu_op, pc_write_cond}), 32'h5);
         applyStimulus("beq.branch", 1, 1, 6'h04, 1);
         checkOutput("beq.count", 32'(retired), 32'(n % 16));
      end
      drain();

      // run dropped in EXEC_R still completes the instruction
      saved = m_retired;
      applyStimulus("drop.idle",   1, 1, 6'h00, 1);
      applyStimulus("drop.fetch",  1, 1, 6'h00, 1);
      applyStimulus("drop.decode", 1, 1, 6'h00, 1);
      applyStimulus("drop.exec",   1, 0, 6'h00, 1);
      applyStimulus("drop.wb",     1, 0, 6'h00, 1);
      checkOutput("drop.retired", 32'(retired), 32'((saved + 1) % 16));
      checkOutput("drop.idle_busy", 32'(busy), 32'd0);

      // reset while fetch is stalled
      applyStimulus("fst.idle",  1, 1, 6'h00, 0);
      applyStimulus("fst.stall", 1, 1, 6'h00, 0);
      applyStimulus("fst.stall", 1, 1, 6'h00, 0);
      applyStimulus("fst.rst",   0, 1, 6'h00, 0);
      checkOutput("fst.outs", 32'(obs_vec), 32'd0);
      checkOutput("fst.retired", 32'(retired), 32'd0);

      // random traffic
      for (int c = 0; c < 600; c++) begin
         applyStimulus("rand",
                       1'($urandom_range(0, 59) != 0),
                       1'($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 4)],
                       1'($urandom_range(0, 2) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
